regfile: RTL and testbench



---
 rtl/regfile.sv | 59 +++++
 tb/tb_regfile.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// 32x32 architectural register file: one write port, two combinational read ports, $0 reads zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile #(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int NREG = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re1,
   input  logic [AW-1:0] raddr1,
   output logic [DW-1:0] rdata1,
   input  logic          re2,
   input  logic [AW-1:0] raddr2,
   output logic [DW-1:0] rdata2
);

   logic [DW-1:0] regs [NREG];
   logic          wr_ok;

   assign wr_ok = we && (waddr != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[waddr] <= wdata;
      end
   end

   // Read ports: reset, enable and $0 all force zero ahead of any data source.
   always_comb begin
      rdata1 = '0;
      if (rst_n && re1 && (raddr1 != '0)) begin
`ifdef REGFILE_BYPASS_EN
         if (we && (waddr == raddr1)) rdata1 = wdata;
         else                         rdata1 = regs[raddr1];
`else
         rdata1 = regs[raddr1];
`endif
      end
   end

   always_comb begin
      rdata2 = '0;
      if (rst_n && re2 && (raddr2 != '0)) begin
`ifdef REGFILE_BYPASS_EN
         if (we && (waddr == raddr2)) rdata2 = wdata;
         else                         rdata2 = regs[raddr2];
`else
         rdata2 = regs[raddr2];
`endif
      end
   end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: stimulus pushes expected read data, a monitor pops and compares.
module tb_regfile;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          re1;
   logic [AW-1:0] raddr1;
   logic [DW-1:0] rdata1;
   logic          re2;
   logic [AW-1:0] raddr2;
   logic [DW-1:0] rdata2;

   typedef struct {
      logic [DW-1:0] exp1;
      logic [DW-1:0] exp2;
      string         tag;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   regfile #(.DW(DW), .AW(AW), .NREG(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .we(we), .waddr(waddr), .wdata(wdata),
      .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
      .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
   );

   always #5 clk = ~clk;

   // Drive a full input vector at the falling edge; any write commits on the next rising edge.
   task automatic cyc(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic r1, input logic [AW-1:0] a1,
                      input logic r2, input logic [AW-1:0] a2);
      @(negedge clk);
      we = w; waddr = wa; wdata = wd;
      re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
   endtask

   task automatic expect_rd(input logic [DW-1:0] e1, input logic [DW-1:0] e2, input string tag);
      exp_t e;
      e.exp1 = e1; e.exp2 = e2; e.tag = tag;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         wait (q.size() > 0);
         #1;
         e = q.pop_front();
         checks++;
         if (rdata1 !== e.exp1 || rdata2 !== e.exp2) begin
            failures++;
            $display("FAIL %s: rdata1=%h rdata2=%h expected rdata1=%h rdata2=%h",
                     e.tag, rdata1, rdata2, e.exp1, e.exp2);
         end
      end
   end

   initial begin : stimulus
      int budget;
      rst_n = 1'b0;
      we = 0; waddr = '0; wdata = '0; re1 = 0; raddr1 = '0; re2 = 0; raddr2 = '0;

      cyc(0, 0, 0, 1, 5, 1, 5);
      expect_rd(32'h0, 32'h0, "por_reset");

      // Reset clear: write $5, pulse reset 3 cycles (writes attempted during reset are lost).
      @(negedge clk); rst_n = 1'b1;
      cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 5, 0, 5);
      expect_rd(32'hDEADBEEF, 32'h0, "wr5_before_reset");
      for (int i = 0; i < 3; i++) begin
         cyc(1, 5, 32'h00000001, 1, 5, 1, 5);
         rst_n = 1'b0;
         expect_rd(32'h0, 32'h0, "during_reset");
      end
      cyc(0, 0, 0, 1, 5, 1, 5);
      rst_n = 1'b1;
      expect_rd(32'h0, 32'h0, "after_reset_r5");

      // Basic write/read on $31, then drop re2.
      cyc(1, 31, 32'h12345678, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 31, 1, 31);
      expect_rd(32'h12345678, 32'h12345678, "r31_both");
      cyc(0, 0, 0, 1, 31, 0, 31);
      expect_rd(32'h12345678, 32'h0, "r31_re2_off");

      // $0 immutability, including same-cycle read of $0 during the write.
      cyc(1, 0, 32'hFFFFFFFF, 1, 0, 1, 0);
      expect_rd(32'h0, 32'h0, "r0_during_wr");
      cyc(0, 0, 0, 1, 0, 1, 0);
      expect_rd(32'h0, 32'h0, "r0_after_wr");

      // Same-cycle hazard on $7.
      cyc(1, 7, 32'h00000001, 0, 0, 0, 0);
      cyc(1, 7, 32'hA5A5A5A5, 1, 7, 1, 31);
`ifdef REGFILE_BYPASS_EN
      expect_rd(32'hA5A5A5A5, 32'h12345678, "hazard_same_cycle");
`else
      expect_rd(32'h00000001, 32'h12345678, "hazard_same_cycle");
`endif
      cyc(0, 0, 0, 1, 7, 1, 7);
      expect_rd(32'hA5A5A5A5, 32'hA5A5A5A5, "hazard_next_cycle");

      // Dual-port independence while writing $9.
      cyc(1, 3, 32'h3, 0, 0, 0, 0);
      cyc(1, 4, 32'h4, 0, 0, 0, 0);
      cyc(1, 9, 32'h99, 1, 3, 1, 4);
      expect_rd(32'h3, 32'h4, "dual_port_indep");
      cyc(0, 0, 0, 1, 9, 1, 3);
      expect_rd(32'h99, 32'h3, "r9_after_wr");

      // Write disable.
      cyc(1, 10, 32'h55, 0, 0, 0, 0);
      cyc(0, 10, 32'hCAFE, 1, 10, 0, 10);
      expect_rd(32'h55, 32'h0, "we0_same_cycle");
      cyc(0, 0, 0, 1, 10, 1, 10);
      expect_rd(32'h55, 32'h55, "we0_after_edge");

      // Full-width data paths, re1 off.
      cyc(1, 1, 32'hFFFFFFFF, 0, 0, 0, 0);
      cyc(1, 2, 32'h80000001, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 1, 2);
      expect_rd(32'hFFFFFFFF, 32'h80000001, "full_width");
      cyc(0, 0, 0, 0, 1, 1, 2);
      expect_rd(32'h0, 32'h80000001, "re1_off");

      budget = 100;
      while (q.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: pending=%0d required=0", q.size());
      end
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
